multiport_reorder_buffer: RTL and testbench

MULTIPORT_REORDER_BUFFER -- requirements
Module: multiport_reorder_buffer

---
 rtl/instruction_type.sv | 13 +
 rtl/rob_pkg.sv | 27 ++
 rtl/rob_commit_select.sv | 35 +++
 rtl/multiport_reorder_buffer.sv | 244 ++++++++++++++++++++++++
 tb/tb_multiport_reorder_buffer.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_type.sv
// Instruction class encodings shared by dispatch, the ROB and the commit logic.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package instruction_type;

  typedef enum logic [1:0] {
    INSTR_ALU    = 2'd0,
    INSTR_LOAD   = 2'd1,
    INSTR_STORE  = 2'd2,
    INSTR_BRANCH = 2'd3
  } instr_type_e;

endpackage

// File: rtl/rob_pkg.sv
// Shared reorder-buffer entry layout and helpers.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package rob_pkg;

  import instruction_type::*;

  localparam int DEST_W = 5;

  // Per-entry status; value and PC live in separate XLEN-wide arrays so this
  // struct stays independent of the datapath width.
  typedef struct packed {
    logic               valid;
    logic               data_ready;
    logic               address_valid;
    logic               exception;
    logic               mispredict;
    instr_type_e        itype;
    logic [DEST_W-1:0]  dest;
  } rob_entry_t;

  // Memory operations may only retire once their address has been generated.
  function automatic logic needs_address(input instr_type_e t);
    return (t == INSTR_LOAD) || (t == INSTR_STORE);
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Commit prefix scan: picks the in-order run of retirable lanes starting at head.
// Latency: purely combinational.
// Backpressure: none; a lane that is not ready blocks every later lane.
//
// Ports:
//   lane_ready   - entry head+k is complete and may retire
//   lane_stop    - entry head+k carries an exception or mispredict
//   commit_valid - lanes retiring this cycle (contiguous from lane 0)
//   retire_count - number of set bits in commit_valid
module rob_commit_select #(
  parameter int COMMIT_WIDTH = 2,
  parameter int CNT_W        = 5
) (
  input  logic [COMMIT_WIDTH-1:0] lane_ready,
  input  logic [COMMIT_WIDTH-1:0] lane_stop,
  output logic [COMMIT_WIDTH-1:0] commit_valid,
  output logic [CNT_W-1:0]        retire_count
);

  always_comb begin : scan
    logic chain;
    chain        = 1'b1;
    commit_valid = '0;
    retire_count = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      commit_valid[k] = chain & lane_ready[k];
      if (commit_valid[k]) begin
        retire_count = retire_count + CNT_W'(1);
      end
      // A faulting entry retires itself but closes the group behind it.
      chain = commit_valid[k] & ~lane_stop[k];
    end
  end

endmodule

// File: rtl/multiport_reorder_buffer.sv
// Multi-lane reorder buffer: in-order allocate, out-of-order writeback, in-order retire.
// Latency: dispatch/writeback visible one cycle after the edge; commit_valid is combinational from state.
// Backpressure: dispatch_ready drops unless a full DISPATCH_WIDTH group fits; flush drops that cycle's dispatch.
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   dispatch_*            - allocate lanes (thermometer valid), tags returned on dispatch_tag
//   cdb_*                 - CDB_PORTS result writebacks, lowest port wins on tag collision
//   agu_valid/agu_rob_tag - marks a memory op's address as generated
//   flush/flush_start_tag - squash flush_start_tag..tail-1, tail rewinds to flush_start_tag
//   commit_*              - COMMIT_WIDTH retire lanes read from head
//   head, tail, count, empty, full - occupancy status
module multiport_reorder_buffer
  import instruction_type::*;
  import rob_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ROB_BUF_SIZE   = 16,
  parameter int ROB_TAG_WIDTH  = $clog2(ROB_BUF_SIZE) + 1,
  parameter int DISPATCH_WIDTH = 2,
  parameter int CDB_PORTS      = 2,
  parameter int COMMIT_WIDTH   = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,

  input  logic [DISPATCH_WIDTH-1:0]               dispatch_valid,
  input  logic [DISPATCH_WIDTH*2-1:0]             dispatch_type,
  input  logic [DISPATCH_WIDTH*5-1:0]             dispatch_dest,
  input  logic [DISPATCH_WIDTH*XLEN-1:0]          dispatch_pc,
  output logic                                    dispatch_ready,
  output logic [DISPATCH_WIDTH*ROB_TAG_WIDTH-1:0] dispatch_tag,

  input  logic [CDB_PORTS-1:0]                    cdb_valid,
  input  logic [CDB_PORTS*ROB_TAG_WIDTH-1:0]      cdb_rob_tag,
  input  logic [CDB_PORTS*XLEN-1:0]               cdb_data,
  input  logic [CDB_PORTS-1:0]                    cdb_exception,
  input  logic [CDB_PORTS-1:0]                    cdb_mispredict,

  input  logic                                    agu_valid,
  input  logic [ROB_TAG_WIDTH-1:0]                agu_rob_tag,

  input  logic                                    flush,
  input  logic [ROB_TAG_WIDTH-1:0]                flush_start_tag,

  output logic [COMMIT_WIDTH-1:0]                 commit_valid,
  output logic [COMMIT_WIDTH*2-1:0]               commit_type,
  output logic [COMMIT_WIDTH*5-1:0]               commit_dest,
  output logic [COMMIT_WIDTH*XLEN-1:0]            commit_value,
  output logic [COMMIT_WIDTH-1:0]                 commit_exception,
  output logic [COMMIT_WIDTH-1:0]                 commit_mispredict,
  output logic [COMMIT_WIDTH*XLEN-1:0]            commit_pc,

  output logic [ROB_TAG_WIDTH-1:0]                head,
  output logic [ROB_TAG_WIDTH-1:0]                tail,
  output logic [$clog2(ROB_BUF_SIZE):0]           count,
  output logic                                    empty,
  output logic                                    full
);

  localparam int IDX_W = $clog2(ROB_BUF_SIZE);
  localparam int TAG_W = ROB_TAG_WIDTH;
  localparam int CNT_W = IDX_W + 1;

  rob_entry_t        entries_q [ROB_BUF_SIZE];
  rob_entry_t        entries_d [ROB_BUF_SIZE];
  logic [XLEN-1:0]   value_q   [ROB_BUF_SIZE];
  logic [XLEN-1:0]   value_d   [ROB_BUF_SIZE];
  logic [XLEN-1:0]   pc_q      [ROB_BUF_SIZE];
  logic [XLEN-1:0]   pc_d      [ROB_BUF_SIZE];
  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;

  logic [TAG_W-1:0]        occupancy;
  logic [CNT_W-1:0]        free_slots;
  logic [TAG_W-1:0]        dispatch_cnt;
  logic [TAG_W-1:0]        flush_span;
  logic                    dispatch_fire;
  logic [IDX_W-1:0]        cdb_idx  [CDB_PORTS];
  logic [CDB_PORTS-1:0]    cdb_hit;
  logic [IDX_W-1:0]        agu_idx;
  logic                    agu_hit;
  logic [IDX_W-1:0]        head_idx [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] lane_ready, lane_stop;
  logic [COMMIT_WIDTH-1:0] commit_sel_raw, commit_sel;
  logic [TAG_W-1:0]        retire_raw, retire_cnt;

  // A tag is live when its distance from head is below the occupancy; this
  // uses the wrap bit so a stale tag from a previous lap cannot alias.
  function automatic logic in_flight(input logic [TAG_W-1:0] t,
                                     input logic [TAG_W-1:0] hd,
                                     input logic [TAG_W-1:0] occ);
    logic [TAG_W-1:0] off;
    off = t - hd;
    return off < occ;
  endfunction

  assign occupancy      = tail_q - head_q;
  assign count          = CNT_W'(occupancy);
  assign free_slots     = CNT_W'(ROB_BUF_SIZE) - count;
  assign dispatch_ready = free_slots >= CNT_W'(DISPATCH_WIDTH);
  assign dispatch_fire  = dispatch_ready & ~flush;
  assign flush_span     = tail_q - flush_start_tag;
  assign head           = head_q;
  assign tail           = tail_q;
  assign empty          = (head_q == tail_q);
  assign full           = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
                          (head_q[TAG_W-1] != tail_q[TAG_W-1]);

  always_comb begin
    dispatch_tag = '0;
    dispatch_cnt = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      dispatch_tag[i*TAG_W +: TAG_W] = tail_q + TAG_W'(i);
      dispatch_cnt = dispatch_cnt + TAG_W'(dispatch_valid[i]);
    end
  end

  always_comb begin
    for (int p = 0; p < CDB_PORTS; p++) begin
      cdb_idx[p] = IDX_W'(cdb_rob_tag[p*TAG_W +: TAG_W]);
      cdb_hit[p] = cdb_valid[p] &&
                   in_flight(cdb_rob_tag[p*TAG_W +: TAG_W], head_q, occupancy) &&
                   entries_q[cdb_idx[p]].valid;
    end
    agu_idx = IDX_W'(agu_rob_tag);
    agu_hit = agu_valid && in_flight(agu_rob_tag, head_q, occupancy) &&
              entries_q[agu_idx].valid;
  end

  // Retire lane view of the entries at head..head+COMMIT_WIDTH-1.
  always_comb begin
    lane_ready        = '0;
    lane_stop         = '0;
    commit_type       = '0;
    commit_dest       = '0;
    commit_value      = '0;
    commit_exception  = '0;
    commit_mispredict = '0;
    commit_pc         = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      head_idx[k]   = IDX_W'(head_q + TAG_W'(k));
      lane_ready[k] = entries_q[head_idx[k]].valid &&
                      entries_q[head_idx[k]].data_ready &&
                      (entries_q[head_idx[k]].address_valid ||
                       !needs_address(entries_q[head_idx[k]].itype));
      lane_stop[k]  = entries_q[head_idx[k]].exception ||
                      entries_q[head_idx[k]].mispredict;
      commit_type[k*2 +: 2]       = entries_q[head_idx[k]].itype;
      commit_dest[k*5 +: 5]       = entries_q[head_idx[k]].dest;
      commit_value[k*XLEN +: XLEN] = value_q[head_idx[k]];
      commit_exception[k]         = entries_q[head_idx[k]].exception;
      commit_mispredict[k]        = entries_q[head_idx[k]].mispredict;
      commit_pc[k*XLEN +: XLEN]    = pc_q[head_idx[k]];
    end
  end

  rob_commit_select #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .CNT_W        (TAG_W)
  ) u_commit_select (
    .lane_ready   (lane_ready),
    .lane_stop    (lane_stop),
    .commit_valid (commit_sel_raw),
    .retire_count (retire_raw)
  );

  // Nothing retires while reset is being applied.
  assign commit_sel   = reset ? '0 : commit_sel_raw;
  assign retire_cnt   = reset ? '0 : retire_raw;
  assign commit_valid = commit_sel;

  // Update order matters: writebacks first, then retire/flush clears, so a
  // squashed entry never keeps a same-cycle CDB or AGU write.
  always_comb begin
    entries_d = entries_q;
    value_d   = value_q;
    pc_d      = pc_q;
    head_d    = head_q;
    tail_d    = tail_q;

    // Highest port first so the lowest-numbered port lands last and wins.
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (cdb_hit[p]) begin
        entries_d[cdb_idx[p]].data_ready = 1'b1;
        entries_d[cdb_idx[p]].exception  = cdb_exception[p];
        entries_d[cdb_idx[p]].mispredict = cdb_mispredict[p];
        value_d[cdb_idx[p]]              = cdb_data[p*XLEN +: XLEN];
      end
    end

    if (agu_hit) begin
      entries_d[agu_idx].address_valid = 1'b1;
    end

    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (commit_sel[k]) begin
        entries_d[head_idx[k]] = '0;
      end
    end
    head_d = head_q + retire_cnt;

    if (flush) begin
      for (int i = 0; i < ROB_BUF_SIZE; i++) begin
        if (TAG_W'(i) < flush_span) begin
          entries_d[IDX_W'(flush_start_tag + TAG_W'(i))] = '0;
        end
      end
      tail_d = flush_start_tag;
    end else if (dispatch_fire) begin
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
        if (dispatch_valid[i]) begin
          entries_d[IDX_W'(tail_q + TAG_W'(i))]       = '0;
          entries_d[IDX_W'(tail_q + TAG_W'(i))].valid = 1'b1;
          entries_d[IDX_W'(tail_q + TAG_W'(i))].itype = instr_type_e'(dispatch_type[i*2 +: 2]);
          entries_d[IDX_W'(tail_q + TAG_W'(i))].dest  = dispatch_dest[i*5 +: 5];
          pc_d[IDX_W'(tail_q + TAG_W'(i))]            = dispatch_pc[i*XLEN +: XLEN];
        end
      end
      tail_d = tail_q + dispatch_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROB_BUF_SIZE; i++) begin
        entries_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

  // Payload is qualified by the entry valid bits and needs no reset.
  always_ff @(posedge clk) begin
    value_q <= value_d;
    pc_q    <= pc_d;
  end

endmodule

// File: tb/tb_multiport_reorder_buffer.sv
// Self-checking bench: directed scenarios then random traffic against a queue-based model.
// Latency: model advances at each rising edge; outputs sampled 1-2 ns after the falling edge.
// Backpressure: model honours dispatch_ready from pre-edge occupancy and drops dispatch on flush.
module tb_multiport_reorder_buffer;

  import instruction_type::*;

  localparam int XLEN = 32;
  localparam int SIZE = 8;
  localparam int TAGW = 4;
  localparam int DW   = 2;
  localparam int CP   = 2;
  localparam int CW   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [DW-1:0]     dispatch_valid;
  logic [DW*2-1:0]   dispatch_type;
  logic [DW*5-1:0]   dispatch_dest;
  logic [DW*XLEN-1:0] dispatch_pc;
  logic              dispatch_ready;
  logic [DW*TAGW-1:0] dispatch_tag;
  logic [CP-1:0]     cdb_valid;
  logic [CP*TAGW-1:0] cdb_rob_tag;
  logic [CP*XLEN-1:0] cdb_data;
  logic [CP-1:0]     cdb_exception;
  logic [CP-1:0]     cdb_mispredict;
  logic              agu_valid;
  logic [TAGW-1:0]   agu_rob_tag;
  logic              flush;
  logic [TAGW-1:0]   flush_start_tag;
  logic [CW-1:0]     commit_valid;
  logic [CW*2-1:0]   commit_type;
  logic [CW*5-1:0]   commit_dest;
  logic [CW*XLEN-1:0] commit_value;
  logic [CW-1:0]     commit_exception;
  logic [CW-1:0]     commit_mispredict;
  logic [CW*XLEN-1:0] commit_pc;
  logic [TAGW-1:0]   head, tail;
  logic [3:0]        count;
  logic              empty, full;

  always #5 clk = ~clk;

  multiport_reorder_buffer #(
    .XLEN(XLEN), .ROB_BUF_SIZE(SIZE), .ROB_TAG_WIDTH(TAGW),
    .DISPATCH_WIDTH(DW), .CDB_PORTS(CP), .COMMIT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_type(dispatch_type),
    .dispatch_dest(dispatch_dest), .dispatch_pc(dispatch_pc),
    .dispatch_ready(dispatch_ready), .dispatch_tag(dispatch_tag),
    .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag), .cdb_data(cdb_data),
    .cdb_exception(cdb_exception), .cdb_mispredict(cdb_mispredict),
    .agu_valid(agu_valid), .agu_rob_tag(agu_rob_tag),
    .flush(flush), .flush_start_tag(flush_start_tag),
    .commit_valid(commit_valid), .commit_type(commit_type), .commit_dest(commit_dest),
    .commit_value(commit_value), .commit_exception(commit_exception),
    .commit_mispredict(commit_mispredict), .commit_pc(commit_pc),
    .head(head), .tail(tail), .count(count), .empty(empty), .full(full)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: program-order queue of in-flight instructions plus a
  // free-running head tag; the tag of queue slot j is (m_head + j) mod 16.
  typedef struct {
    logic [1:0]  typ;
    logic [4:0]  dest;
    logic [31:0] val;
    logic [31:0] pc;
    bit          rdy;
    bit          addr;
    bit          exc;
    bit          mis;
  } m_ent_t;

  m_ent_t mq[$];
  int     m_head = 0;

  function automatic int m_pos(input logic [TAGW-1:0] t);
    return (int'(t) - m_head + 16) % 16;
  endfunction

  // How many instructions leave from the front of the queue this cycle.
  function automatic int m_retire();
    int n = 0;
    for (int k = 0; k < CW; k++) begin
      if (k >= mq.size()) break;
      if (!mq[k].rdy) break;
      if ((mq[k].typ == INSTR_LOAD || mq[k].typ == INSTR_STORE) && !mq[k].addr) break;
      n++;
      if (mq[k].exc || mq[k].mis) break;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    dispatch_valid  = '0;
    dispatch_type   = '0;
    dispatch_dest   = '0;
    dispatch_pc     = '0;
    cdb_valid       = '0;
    cdb_rob_tag     = '0;
    cdb_data        = '0;
    cdb_exception   = '0;
    cdb_mispredict  = '0;
    agu_valid       = 1'b0;
    agu_rob_tag     = '0;
    flush           = 1'b0;
    flush_start_tag = '0;
  endtask

  task automatic disp(input logic [1:0] v, input logic [1:0] t0, input logic [1:0] t1,
                      input logic [4:0] d0, input logic [4:0] d1);
    dispatch_valid = v;
    dispatch_type  = {t1, t0};
    dispatch_dest  = {d1, d0};
    dispatch_pc    = {$urandom, $urandom};
  endtask

  task automatic cdb(input int p, input logic [TAGW-1:0] t, input logic [31:0] d,
                     input bit exc, input bit mis);
    cdb_valid[p]                 = 1'b1;
    cdb_rob_tag[p*TAGW +: TAGW]  = t;
    cdb_data[p*XLEN +: XLEN]     = d;
    cdb_exception[p]             = exc;
    cdb_mispredict[p]            = mis;
  endtask

  task automatic compare_all();
    int n  = m_retire();
    int sz = mq.size();
    int tl = (m_head + sz) % 16;
    logic [CW-1:0] ecv = '0;
    for (int k = 0; k < n; k++) ecv[k] = 1'b1;
    chk("head", 64'(head), 64'(m_head));
    chk("tail", 64'(tail), 64'(tl));
    chk("count", 64'(count), 64'(sz));
    chk("empty", 64'(empty), 64'(sz == 0));
    chk("full", 64'(full), 64'(sz == SIZE));
    chk("dispatch_ready", 64'(dispatch_ready), 64'((SIZE - sz) >= DW));
    for (int i = 0; i < DW; i++)
      chk("dispatch_tag", 64'(dispatch_tag[i*TAGW +: TAGW]), 64'((tl + i) % 16));
    chk("commit_valid", 64'(commit_valid), 64'(ecv));
    for (int k = 0; k < n; k++) begin
      chk("commit_value", 64'(commit_value[k*XLEN +: XLEN]), 64'(mq[k].val));
      chk("commit_pc", 64'(commit_pc[k*XLEN +: XLEN]), 64'(mq[k].pc));
      chk("commit_dest", 64'(commit_dest[k*5 +: 5]), 64'(mq[k].dest));
      chk("commit_type", 64'(commit_type[k*2 +: 2]), 64'(mq[k].typ));
      chk("commit_exception", 64'(commit_exception[k]), 64'(mq[k].exc));
      chk("commit_mispredict", 64'(commit_mispredict[k]), 64'(mq[k].mis));
    end
  endtask

  task automatic model_step();
    int     n;
    int     sz;
    int     pos;
    int     keep;
    bit     can_disp;
    bit     seen [16];
    m_ent_t e;
    if (reset) begin
      mq.delete();
      m_head = 0;
      return;
    end
    n        = m_retire();
    sz       = mq.size();
    can_disp = (SIZE - sz) >= DW;
    for (int t = 0; t < 16; t++) seen[t] = 1'b0;
    // Lowest port claims a tag first; later ports to the same tag are dropped.
    for (int p = 0; p < CP; p++) begin
      if (cdb_valid[p]) begin
        pos = m_pos(cdb_rob_tag[p*TAGW +: TAGW]);
        if (!seen[cdb_rob_tag[p*TAGW +: TAGW]] && pos < sz) begin
          e     = mq[pos];
          e.val = cdb_data[p*XLEN +: XLEN];
          e.rdy = 1'b1;
          e.exc = cdb_exception[p];
          e.mis = cdb_mispredict[p];
          mq[pos] = e;
        end
        seen[cdb_rob_tag[p*TAGW +: TAGW]] = 1'b1;
      end
    end
    if (agu_valid) begin
      pos = m_pos(agu_rob_tag);
      if (pos < sz) begin
        e      = mq[pos];
        e.addr = 1'b1;
        mq[pos] = e;
      end
    end
    for (int j = 0; j < n; j++) void'(mq.pop_front());
    if (flush) begin
      keep = m_pos(flush_start_tag) - n;
      while (mq.size() > keep) void'(mq.pop_back());
    end else if (can_disp) begin
      for (int i = 0; i < DW; i++) begin
        if (dispatch_valid[i]) begin
          e.typ  = dispatch_type[i*2 +: 2];
          e.dest = dispatch_dest[i*5 +: 5];
          e.val  = '0;
          e.pc   = dispatch_pc[i*XLEN +: XLEN];
          e.rdy  = 1'b0;
          e.addr = 1'b0;
          e.exc  = 1'b0;
          e.mis  = 1'b0;
          mq.push_back(e);
        end
      end
    end
    m_head = (m_head + n) % 16;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    #1;
    if (!reset) compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    int n;
    int sz;
    logic [1:0] v;

    set_idle();
    reset = 1'b1;
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    chk("rst_head", 64'(head), 64'd0);
    chk("rst_tail", 64'(tail), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_dispatch_ready", 64'(dispatch_ready), 64'd1);

    // Two ALU ops get tags 0 and 1.
    disp(2'b11, INSTR_ALU, INSTR_ALU, 5'd10, 5'd11);
    #1;
    chk("a_tag0", 64'(dispatch_tag[3:0]), 64'd0);
    chk("a_tag1", 64'(dispatch_tag[7:4]), 64'd1);
    cycle();
    set_idle();
    #1;
    chk("a_tail", 64'(tail), 64'd2);
    chk("a_count", 64'(count), 64'd2);
    chk("a_commit_valid", 64'(commit_valid), 64'd0);

    // Both CDB ports write the same edge, out of order.
    cdb(0, 4'd1, 32'hAAAA, 1'b0, 1'b0);
    cdb(1, 4'd0, 32'h5555, 1'b0, 1'b0);
    cycle();
    set_idle();
    #1;
    chk("b_commit_valid", 64'(commit_valid), 64'd3);
    chk("b_value0", 64'(commit_value[31:0]), 64'h5555);
    chk("b_value1", 64'(commit_value[63:32]), 64'hAAAA);
    cycle();
    #1;
    chk("b_empty", 64'(empty), 64'd1);
    chk("b_head", 64'(head), 64'd2);

    // A store waits for its address even with data present.
    disp(2'b01, INSTR_STORE, INSTR_ALU, 5'd3, 5'd0);
    cycle();
    set_idle();
    cdb(0, 4'd2, 32'h1234, 1'b0, 1'b0);
    cycle();
    set_idle();
    #1;
    chk("c_no_addr", 64'(commit_valid), 64'd0);
    agu_valid   = 1'b1;
    agu_rob_tag = 4'd2;
    cycle();
    set_idle();
    #1;
    chk("c_addr", 64'(commit_valid), 64'd1);
    cycle();

    // Fill to capacity, then retire while refilling across the index wrap.
    repeat (4) begin
      set_idle();
      disp(2'b11, INSTR_ALU, INSTR_BRANCH, 5'($urandom), 5'($urandom));
      cycle();
    end
    set_idle();
    #1;
    chk("d_full", 64'(full), 64'd1);
    chk("d_ready", 64'(dispatch_ready), 64'd0);
    cdb(0, 4'd3, 32'h33, 1'b0, 1'b0);
    cdb(1, 4'd4, 32'h44, 1'b0, 1'b0);
    cycle();
    set_idle();
    cdb(0, 4'd5, 32'h55, 1'b0, 1'b0);
    cdb(1, 4'd6, 32'h66, 1'b0, 1'b0);
    disp(2'b11, INSTR_ALU, INSTR_ALU, 5'd1, 5'd2);
    cycle();
    set_idle();
    disp(2'b11, INSTR_ALU, INSTR_ALU, 5'd3, 5'd4);
    cycle();
    set_idle();
    #1;
    chk("d_count_overlap", 64'(count), 64'd6);
    disp(2'b11, INSTR_LOAD, INSTR_ALU, 5'd5, 5'd6);
    cycle();
    set_idle();
    #1;
    chk("d_count8", 64'(count), 64'd8);
    chk("d_tail_wrap", 64'(tail[3]), 64'd1);
    chk("d_full2", 64'(full), 64'd1);

    // Reset wins over a same-cycle dispatch and writeback.
    reset = 1'b1;
    disp(2'b11, INSTR_ALU, INSTR_ALU, 5'd7, 5'd8);
    cdb(0, 4'd3, 32'h99, 1'b0, 1'b0);
    cycle();
    reset = 1'b0;
    set_idle();
    #1;
    chk("g_empty", 64'(empty), 64'd1);
    chk("g_tail", 64'(tail), 64'd0);
    chk("g_commit_valid", 64'(commit_valid), 64'd0);

    // Bring head to 2, allocate 2..6, mispredict on 3, flush from 4.
    disp(2'b11, INSTR_ALU, INSTR_ALU, 5'd1, 5'd2);
    cycle();
    set_idle();
    cdb(0, 4'd0, 32'h10, 1'b0, 1'b0);
    cdb(1, 4'd1, 32'h11, 1'b0, 1'b0);
    cycle();
    set_idle();
    cycle();
    disp(2'b11, INSTR_ALU, INSTR_BRANCH, 5'd2, 5'd3);
    cycle();
    set_idle();
    disp(2'b11, INSTR_ALU, INSTR_ALU, 5'd4, 5'd5);
    cdb(0, 4'd3, 32'h33, 1'b0, 1'b1);
    cycle();
    set_idle();
    disp(2'b01, INSTR_ALU, INSTR_ALU, 5'd6, 5'd0);
    cycle();
    set_idle();
    #1;
    chk("e_count5", 64'(count), 64'd5);
    chk("e_tail7", 64'(tail), 64'd7);
    flush           = 1'b1;
    flush_start_tag = 4'd4;
    cdb(0, 4'd5, 32'h55, 1'b0, 1'b0);
    disp(2'b11, INSTR_ALU, INSTR_ALU, 5'd9, 5'd9);
    cycle();
    set_idle();
    #1;
    chk("e_tail4", 64'(tail), 64'd4);
    chk("e_count2", 64'(count), 64'd2);
    chk("e_commit_valid", 64'(commit_valid), 64'd0);
    cdb(0, 4'd2, 32'h22, 1'b0, 1'b0);
    cycle();
    set_idle();
    #1;
    chk("e_commit_both", 64'(commit_valid), 64'd3);
    chk("e_mis_lane1", 64'(commit_mispredict[1]), 64'd1);
    chk("e_mis_lane0", 64'(commit_mispredict[0]), 64'd0);
    cycle();

    // Exception at head closes the group even though head+1 is ready.
    disp(2'b11, INSTR_ALU, INSTR_ALU, 5'd12, 5'd13);
    cycle();
    set_idle();
    cdb(0, 4'd4, 32'h44, 1'b1, 1'b0);
    cdb(1, 4'd5, 32'h45, 1'b0, 1'b0);
    cycle();
    set_idle();
    #1;
    chk("f_commit_valid", 64'(commit_valid), 64'd1);
    chk("f_exc_lane0", 64'(commit_exception[0]), 64'd1);
    cycle();
    #1;
    chk("f_head", 64'(head), 64'd5);
    chk("f_next", 64'(commit_valid), 64'd1);
    cycle();

    // Random traffic against the model.
    for (int it = 0; it < 800; it++) begin
      set_idle();
      n  = m_retire();
      sz = mq.size();
      case ($urandom % 4)
        0:       v = 2'b00;
        1:       v = 2'b01;
        default: v = 2'b11;
      endcase
      disp(v, 2'($urandom), 2'($urandom), 5'($urandom), 5'($urandom));
      for (int p = 0; p < CP; p++) begin
        if ($urandom % 3 != 0)
          cdb(p, 4'((m_head + int'($urandom % (sz + 1))) % 16), $urandom,
              ($urandom % 10) == 0, ($urandom % 10) == 0);
      end
      if ($urandom % 2 == 0) begin
        agu_valid   = 1'b1;
        agu_rob_tag = 4'((m_head + int'($urandom % (sz + 1))) % 16);
      end
      if ($urandom % 16 == 0) begin
        flush           = 1'b1;
        flush_start_tag = 4'((m_head + n + int'($urandom_range(0, sz - n))) % 16);
      end
      cycle();
    end

    set_idle();
    cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
